afifo_wr_arb: RTL
=================

# afifo_wr_arb

Write-side arbiter that shares the single write port of the team's asynchronous FIFO among NREQ requesters in the write clock domain. Ownership is granted round-robin in bursts of BURST words, so each 4-word group read out on the FIFO's read side comes from a single source. The block sits between the requester ports and the FIFO's wren/wdata/wfull pins and runs entirely on wclk.

## Interface
- NREQ, 4, number of requesters, 2..8
- dsize, 8, data word width; equals the FIFO data width
- BURST, 4, words per grant; a power of two, at least 2; equals the FIFO read group size
- wclk  input  1  write clock; all logic is on the rising edge
- wrstn  input  1  synchronous, active-low reset
- req  input  NREQ  bit i high: requester i has a word ready
- reqdata  input  NREQ*dsize  word of requester i at [i*dsize +: dsize]
- fifo_wfull  input  1  FIFO full flag
- gnt  output  NREQ  registered one-hot owner of the write port; all zero when idle
- ack  output  NREQ  combinational; bit i high: the word on requester i is consumed this cycle
- fifo_wren  output  1  combinational FIFO write enable
- fifo_wdata  output  dsize  combinational; reqdata slice of the owner
- bcnt  output  log2(BURST)  registered count of words written in the current burst
- busy  output  1  registered; high in state BURST

## Operation
- States:
  - IDLE: gnt=0, busy=0.
  - BURST: gnt one-hot, busy=1.
- Pointer ptr (log2(NREQ) bits) holds the highest-priority index. Search order is ptr, ptr+1, …, ptr+NREQ-1, modulo NREQ.
- IDLE -> BURST when any req bit is high. The winner is the first req bit high in search order. gnt is loaded with the winner's one-hot code and bcnt is set to 0.
- In BURST, with owner o:
  - fifo_wren = req[o] & ~fifo_wfull.
  - fifo_wdata = reqdata[o*dsize +: dsize].
  - ack = gnt when fifo_wren is high, else 0.
- Each write increments bcnt, wrapping modulo BURST.
- BURST -> IDLE on the write with bcnt == BURST-1. On that edge gnt clears, bcnt becomes 0 and ptr becomes (o+1) mod NREQ.
- In IDLE: fifo_wren=0, ack=0 and fifo_wdata=0.
- The grant is never withdrawn mid-burst. If the owner drops req, the block waits with no write and holds bcnt. Other requesters are ignored until the burst completes. Requesters are required to deliver whole bursts.
- fifo_wfull high:
  - No write that cycle; bcnt and state hold.
  - The burst resumes on the first cycle with wfull low and req[o] high.
- Several req bits rise at once: only the first in search order is granted. The others stay pending with no ack.
- Reset (wrstn=0 at a rising edge), including mid-burst:
  - State goes to IDLE; gnt=0, bcnt=0, busy=0, ptr=0.
  - The same cycle, combinational outputs are forced to fifo_wren=0, ack=0, fifo_wdata=0.
  - Words already written are not retracted. The FIFO is reset by the same wrstn.
- Reset values: gnt=0, ack=0, fifo_wren=0, fifo_wdata=0, bcnt=0, busy=0.

## Timing
- Arbitration latency: req rises in cycle N (IDLE) -> gnt and busy high from cycle N+1.
- The first fifo_wren is in cycle N+1 at the earliest.
- Burst duration: BURST cycles minimum, plus one cycle per wfull stall or owner req gap.
- After the final write the block spends one cycle in IDLE. Peak throughput is BURST words per BURST+1 cycles.
- ack and fifo_wren are the same-cycle accept strobe. The requester advances its data on the wclk edge where ack[i] is high.
- fifo_wfull is sampled combinationally. The FIFO also gates writes on wfull; both gates agree.

## Test plan
- Single requester: req[2]=1 continuously, data 0x10..0x17.
  - gnt=0b0100 from cycle 1.
  - Writes 0x10..0x13 in cycles 1-4, then IDLE in cycle 5.
  - Second burst 0x14..0x17 in cycles 6-9.
- Round robin: req=0b1111 held.
  - Grant order is 0,1,2,3,0, with exactly 4 writes each and 5 cycles per grant.
  - ack is never asserted for a non-owner.
- wfull stall: fifo_wfull high for 3 cycles after the 2nd write of a burst.
  - fifo_wren=0 and bcnt stays 2 while full.
  - The burst completes with the remaining 2 words; exactly 4 words total.
- Owner gap: req[1] drops after 1 word for 5 cycles while req[3]=1.
  - gnt stays 0b0010, bcnt=1 and no writes during the gap.
  - After the gap, req[1] finishes its 3 words, then gnt=0b1000.
- Reset mid-burst: wrstn=0 after 2 writes of owner 2.
  - Next cycle: gnt=0, bcnt=0, busy=0, fifo_wren=0.
  - After release with req=0b1111, the first grant goes to requester 0 (ptr=0).
- Simultaneous request, NREQ=4: ptr=3 after a burst by owner 2, then req=0b1001.
  - Requester 3 is granted first, then requester 0.

Source files
------------

// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb
// Shares the single write port of an asynchronous FIFO among NREQ requesters
// in the write clock domain. The port is granted round-robin in bursts of
// BURST words, so each BURST-word group seen on the FIFO read side comes from
// one source.
//
// Ports:
//   wclk        write clock; all state changes on its rising edge
//   wrstn       synchronous active-low reset
//   req         per-requester "word ready" flags
//   reqdata     requester i's word at [i*dsize +: dsize]
//   fifo_wfull  FIFO full flag (used combinationally)
//   gnt         registered one-hot owner, zero when idle
//   ack         combinational accept strobe per requester
//   fifo_wren   combinational FIFO write enable
//   fifo_wdata  combinational write data (owner's word, zero when idle)
//   bcnt        registered count of words written in the current burst
//   busy        registered, high while a burst is owned
module afifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int dsize = 8,
  parameter int BURST = 4,
  localparam int BW   = $clog2(BURST),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*dsize-1:0] reqdata,
  input  logic                  fifo_wfull,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_wren,
  output logic [dsize-1:0]      fifo_wdata,
  output logic [BW-1:0]         bcnt,
  output logic                  busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic [PW-1:0]     owner_reg;
  logic [PW-1:0]     ptr_reg;
  logic [BW-1:0]     bcnt_reg;
  logic              busy_reg;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic              wr;
  logic [dsize-1:0]  words [NREQ];

  // Split the flat data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
      assign words[gi] = reqdata[gi*dsize +: dsize];
    end
  endgenerate

  // Round-robin search starting at ptr. Scanning from the far end back
  // towards ptr lets the last hit be the first one in search order.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_reg) + k) % NREQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A word moves only while owned, the owner offers one, and the FIFO has
  // room. Reset low forces every combinational output quiet the same cycle.
  assign wr         = wrstn && (state_reg == S_BURST) && req[owner_reg] && !fifo_wfull;
  assign fifo_wren  = wr;
  assign ack        = wr ? gnt_reg : '0;
  assign fifo_wdata = (wrstn && (state_reg == S_BURST)) ? words[owner_reg] : '0;

  assign gnt  = gnt_reg;
  assign bcnt = bcnt_reg;
  assign busy = busy_reg;

  always_ff @(posedge wclk) begin
    if (!wrstn) begin
      state_reg <= S_IDLE;
      gnt_reg   <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      bcnt_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (win_found) begin
            state_reg <= S_BURST;
            gnt_reg   <= NREQ'(1) << win_idx;
            owner_reg <= win_idx;
            bcnt_reg  <= '0;
            busy_reg  <= 1'b1;
          end
        end
        S_BURST: begin
          // Stalls (full FIFO or owner gap) simply hold everything.
          if (wr) begin
            if (bcnt_reg == BW'(BURST - 1)) begin
              state_reg <= S_IDLE;
              gnt_reg   <= '0;
              bcnt_reg  <= '0;
              busy_reg  <= 1'b0;
              ptr_reg   <= (owner_reg == PW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
            end else begin
              bcnt_reg <= bcnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
